// File: rtl/violation_alert_scheduler.sv
// ---------------------------------------------------------------------------
// violation_alert_scheduler: round-robin merge of violation codes into 3-byte
// serial alert frames. Optional macro ALERT_MERGE_CNT_EN. Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module violation_alert_scheduler #(
  parameter int NUM_SRC = 4,
  parameter int MCNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC-1:0]     evt_valid,
  input  logic [2*NUM_SRC-1:0]   evt_code,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic [NUM_SRC-1:0]     pending,
  output logic [MCNT_W-1:0]      merge_cnt
);

  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TYPE = 2'd1,
    S_ID   = 2'd2,
    S_EOL  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_SRC-1:0]   pending_q, pending_d;
  logic [2*NUM_SRC-1:0] code_q, code_d;
  logic [ID_W-1:0]      last_grant_q, last_grant_d;
  logic [ID_W-1:0]      src_id_q, src_id_d;
  logic [1:0]           frame_code_q, frame_code_d;

  logic                 grant_found;
  logic [ID_W-1:0]      grant_idx;
  logic                 grant_fire;
  logic [NUM_SRC-1:0]   evt_hit;
  logic [NUM_SRC-1:0]   granted_oh;

  // Search starts one past the last winner so every source gets its turn.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int off = 1; off <= NUM_SRC; off++) begin
      idx = (int'(last_grant_q) + off) % NUM_SRC;
      if (!grant_found && pending_q[ID_W'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  assign grant_fire = (state_q == S_IDLE) && grant_found;

  always_comb begin
    evt_hit    = '0;
    granted_oh = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      evt_hit[i]    = evt_valid[i] && (evt_code[2*i +: 2] != 2'b00);
      granted_oh[i] = grant_fire && (grant_idx == ID_W'(i));
    end
  end

  // A source granted this cycle hands its old code to the frame; a new event
  // in the same cycle starts a fresh entry instead of merging.
  always_comb begin
    pending_d = pending_q;
    code_d    = code_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (granted_oh[i]) begin
        pending_d[i]      = evt_hit[i];
        code_d[2*i +: 2]  = evt_hit[i] ? evt_code[2*i +: 2] : 2'b00;
      end else if (evt_hit[i]) begin
        pending_d[i]      = 1'b1;
        code_d[2*i +: 2]  = pending_q[i] ? (code_q[2*i +: 2] | evt_code[2*i +: 2])
                                         : evt_code[2*i +: 2];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    src_id_d     = src_id_q;
    frame_code_d = frame_code_q;
    last_grant_d = last_grant_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          state_d      = S_TYPE;
          src_id_d     = grant_idx;
          frame_code_d = code_q[{grant_idx, 1'b0} +: 2];
          last_grant_d = grant_idx;
        end
      end
      S_TYPE:  if (tx_ready) state_d = S_ID;
      S_ID:    if (tx_ready) state_d = S_EOL;
      S_EOL:   if (tx_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pending_q    <= '0;
      code_q       <= '0;
      last_grant_q <= ID_W'(NUM_SRC - 1);
      src_id_q     <= '0;
      frame_code_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      code_q       <= code_d;
      last_grant_q <= last_grant_d;
      src_id_q     <= src_id_d;
      frame_code_q <= frame_code_d;
    end
  end

  always_comb begin
    tx_data = 8'h00;
    case (state_q)
      S_TYPE: begin
        case (frame_code_q)
          2'b01:   tx_data = 8'h52;
          2'b10:   tx_data = 8'h50;
          2'b11:   tx_data = 8'h42;
          default: tx_data = 8'h00;
        endcase
      end
      S_ID:    tx_data = 8'h30 + 8'(src_id_q);
      S_EOL:   tx_data = 8'h0A;
      default: tx_data = 8'h00;
    endcase
  end

  assign tx_valid = (state_q != S_IDLE);
  assign busy     = (|pending_q) || (state_q != S_IDLE);
  assign pending  = pending_q;

`ifdef ALERT_MERGE_CNT_EN
  localparam logic [31:0] MCNT_MAX = (MCNT_W >= 32) ? 32'hFFFF_FFFF
                                                    : ((32'd1 << MCNT_W) - 32'd1);

  logic [MCNT_W-1:0] merge_cnt_q, merge_cnt_d;
  logic [31:0]       merge_num;
  logic [31:0]       mcnt_sum;

  always_comb begin
    merge_num = 32'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (evt_hit[i] && pending_q[i] && !granted_oh[i]) merge_num = merge_num + 32'd1;
    end
    mcnt_sum    = 32'(merge_cnt_q) + merge_num;
    merge_cnt_d = (mcnt_sum > MCNT_MAX) ? {MCNT_W{1'b1}} : mcnt_sum[MCNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) merge_cnt_q <= '0;
    else     merge_cnt_q <= merge_cnt_d;
  end

  assign merge_cnt = merge_cnt_q;
`else
  assign merge_cnt = '0;
`endif

endmodule

`default_nettype wire
